// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering one load/store at a time; RspValid rises LATENCY edges after acceptance.
// No request queueing: ReqReady only in IDLE, and the response is held until RspReady.
module data_mem_responder #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [11:0] ReqAddr,
    input  logic [31:0] ReqWData,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspData,
    output logic        RspErr,
    output logic        Busy
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        busy_q, busy_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        eff_write, eff_signed, misaligned, enter_resp, mem_we;
    logic [11:0] eff_addr;
    logic [31:0] eff_wdata, mem_rd, wr_word, ld_val, lane_shift;
    logic [1:0]  eff_size;
    logic [AW-1:0] eff_idx;

    // With LATENCY=1 the request goes straight to RESP, so the live inputs stand in for the latched copy.
    always_comb begin
        eff_write  = (state_q == IDLE) ? ReqWrite  : write_q;
        eff_addr   = (state_q == IDLE) ? ReqAddr   : addr_q;
        eff_wdata  = (state_q == IDLE) ? ReqWData  : wdata_q;
        eff_size   = (state_q == IDLE) ? ReqSize   : size_q;
        eff_signed = (state_q == IDLE) ? ReqSigned : signed_q;
        eff_idx    = eff_addr[AW+1:2];
        mem_rd     = mem[eff_idx];

        case (eff_size)
            2'b01:   misaligned = eff_addr[0];
            2'b10:   misaligned = 1'b0;
            default: misaligned = (eff_addr[1:0] != 2'b00);
        endcase

        lane_shift = mem_rd >> {eff_addr[1:0], 3'b000};
        case (eff_size)
            2'b10:   ld_val = eff_signed ? {{24{lane_shift[7]}}, lane_shift[7:0]}
                                         : {24'b0, lane_shift[7:0]};
            2'b01:   ld_val = eff_signed ? {{16{lane_shift[15]}}, lane_shift[15:0]}
                                         : {16'b0, lane_shift[15:0]};
            default: ld_val = mem_rd;
        endcase

        wr_word = mem_rd;
        case (eff_size)
            2'b10:   wr_word[{eff_addr[1:0], 3'b000} +: 8]  = eff_wdata[7:0];
            2'b01:   wr_word[{eff_addr[1], 4'b0000} +: 16]  = eff_wdata[15:0];
            default: wr_word = eff_wdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        signed_d   = signed_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: if (ReqValid) begin
                write_d  = ReqWrite;
                addr_d   = ReqAddr;
                wdata_d  = ReqWData;
                size_d   = ReqSize;
                signed_d = ReqSigned;
                if (LATENCY == 1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            WAIT: if (cnt_q == 4'd1) begin
                state_d    = RESP;
                cnt_d      = 4'd0;
                enter_resp = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP: if (RspReady) begin
                state_d    = IDLE;
                rsp_data_d = 32'b0;
                rsp_err_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            rsp_err_d  = misaligned;
            rsp_data_d = (!eff_write && !misaligned) ? ld_val : 32'b0;
        end
        mem_we      = enter_resp && eff_write && !misaligned;
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= 12'b0;
            wdata_q     <= 32'b0;
            size_q      <= 2'b0;
            signed_q    <= 1'b0;
            rsp_data_q  <= 32'b0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Storage survives reset; a reset edge suppresses any commit that would have landed on it.
    always_ff @(posedge Clk) begin
        if (Rst && mem_we) mem[eff_idx] <= wr_word;
    end

    assign ReqReady = (state_q == IDLE);
    assign RspValid = rsp_valid_q;
    assign RspData  = rsp_data_q;
    assign RspErr   = rsp_err_q;
    assign Busy     = busy_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY=2 with hand-computed expected values.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [11:0] req_addr = 12'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    data_mem_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) dut (
        .Clk(clk), .Rst(rst),
        .ReqValid(req_valid), .ReqReady(req_ready), .ReqWrite(req_write),
        .ReqAddr(req_addr), .ReqWData(req_wdata), .ReqSize(req_size), .ReqSigned(req_signed),
        .RspValid(rsp_valid), .RspReady(rsp_ready), .RspData(rsp_data), .RspErr(rsp_err),
        .Busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, scramble the inputs after acceptance, wait for the response and consume it.
    task automatic transact(input logic w, input logic [11:0] a, input logic [31:0] wd,
                            input logic [1:0] sz, input logic sg,
                            output logic [31:0] data, output logic err, output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 40) begin tick(); n++; end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
        req_size = sz; req_signed = sg;
        tick();
        req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~wd; req_signed = ~sg;
        lat = 1;
        while (!rsp_valid && lat < 40) begin tick(); lat++; end
        if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        data = rsp_data;
        err  = rsp_err;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    logic [31:0] d;
    logic        e;
    int          lat;
    int          n;

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_rspvalid", 32'(rsp_valid), 32'd0);
        chk("rst_rspdata", rsp_data, 32'h0);
        chk("rst_rsperr", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        chk("rst_reqready", 32'(req_ready), 32'd1);
        tick();

        // Word store then load
        transact(1'b1, 12'h040, 32'hDEADBEEF, 2'b00, 1'b0, d, e, lat);
        chk("st_word_data", d, 32'h0);
        chk("st_word_err", 32'(e), 32'd0);
        chk("st_word_lat", 32'(lat), 32'd2);
        transact(1'b0, 12'h040, 32'h0, 2'b00, 1'b0, d, e, lat);
        chk("ld_word_data", d, 32'hDEADBEEF);
        chk("ld_word_err", 32'(e), 32'd0);
        chk("ld_word_lat", 32'(lat), 32'd2);

        // Partial lanes and extension
        transact(1'b1, 12'h041, 32'h0000007F, 2'b10, 1'b0, d, e, lat);
        chk("st_byte_err", 32'(e), 32'd0);
        transact(1'b0, 12'h040, 32'h0, 2'b00, 1'b0, d, e, lat);
        chk("ld_after_byte", d, 32'hDEAD7FEF);
        transact(1'b0, 12'h043, 32'h0, 2'b10, 1'b1, d, e, lat);
        chk("ld_sbyte_43", d, 32'hFFFFFFDE);
        transact(1'b0, 12'h041, 32'h0, 2'b10, 1'b0, d, e, lat);
        chk("ld_ubyte_41", d, 32'h0000007F);
        transact(1'b0, 12'h042, 32'h0, 2'b01, 1'b0, d, e, lat);
        chk("ld_uhalf_42", d, 32'h0000DEAD);
        transact(1'b0, 12'h042, 32'h0, 2'b01, 1'b1, d, e, lat);
        chk("ld_shalf_42", d, 32'hFFFFDEAD);
        transact(1'b1, 12'h046, 32'hFFFF8001, 2'b01, 1'b0, d, e, lat);
        transact(1'b0, 12'h044, 32'h0, 2'b11, 1'b0, d, e, lat);
        chk("ld_after_half_hi", d[31:16], 32'h8001);

        // Misalignment
        transact(1'b0, 12'h042, 32'h0, 2'b00, 1'b0, d, e, lat);
        chk("mis_word_err", 32'(e), 32'd1);
        chk("mis_word_data", d, 32'h0);
        transact(1'b1, 12'h041, 32'h00001234, 2'b01, 1'b0, d, e, lat);
        chk("mis_half_err", 32'(e), 32'd1);
        transact(1'b0, 12'h040, 32'h0, 2'b00, 1'b0, d, e, lat);
        chk("mis_half_nowrite", d, 32'hDEAD7FEF);
        transact(1'b0, 12'h041, 32'h0, 2'b11, 1'b0, d, e, lat);
        chk("mis_size11_err", 32'(e), 32'd1);
        transact(1'b0, 12'h040, 32'h0, 2'b11, 1'b0, d, e, lat);
        chk("size11_data", d, 32'hDEAD7FEF);

        // Backpressure with a dropped request during the hold
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h040; req_size = 2'b00;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("bp_rspvalid", 32'(rsp_valid), 32'd1);
            chk("bp_rspdata", rsp_data, 32'hDEAD7FEF);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_reqready", 32'(req_ready), 32'd0);
            if (i == 2) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h040;
                req_wdata = 32'h0; req_size = 2'b00;
            end else begin
                req_valid = 1'b0;
            end
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("bp_not_queued", 32'(busy), 32'd0);
        transact(1'b0, 12'h040, 32'h0, 2'b00, 1'b0, d, e, lat);
        chk("bp_drop_nowrite", d, 32'hDEAD7FEF);

        // Reset mid-WAIT discards the store
        transact(1'b1, 12'h080, 32'hAAAAAAAA, 2'b00, 1'b0, d, e, lat);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h080;
        req_wdata = 32'h11111111; req_size = 2'b00;
        tick();
        req_valid = 1'b0;
        chk("wait_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        tick();
        chk("rstw_rspvalid", 32'(rsp_valid), 32'd0);
        chk("rstw_rspdata", rsp_data, 32'h0);
        chk("rstw_rsperr", 32'(rsp_err), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        chk("rstw_reqready", 32'(req_ready), 32'd1);
        transact(1'b0, 12'h080, 32'h0, 2'b00, 1'b0, d, e, lat);
        chk("rstw_mem_kept", d, 32'hAAAAAAAA);

        // Reset in RESP drops the response but keeps the committed store
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h084;
        req_wdata = 32'h55555555; req_size = 2'b00;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin tick(); n++; end
        chk("resp_reached", 32'(rsp_valid), 32'd1);
        rst = 1'b0;
        tick();
        chk("rstr_rspvalid", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        transact(1'b0, 12'h084, 32'h0, 2'b00, 1'b0, d, e, lat);
        chk("rstr_mem_committed", d, 32'h55555555);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
